// File: rtl/iob_e_cycle_pkg.sv
// Shared definitions for the IO bus cycle termination engine and the IO bus master.
package iob_e_cycle_pkg;

    localparam logic [1:0] TERM_DTACK = 2'b00;
    localparam logic [1:0] TERM_VPA   = 2'b01;
    localparam logic [1:0] TERM_BERR  = 2'b10;
    localparam logic [1:0] TERM_TMO   = 2'b11;

    localparam int unsigned E_PERIOD_DEF  = 10;
    localparam int unsigned VMA_PHASE_DEF = 2;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StVpaw,
        StVma,
        StDone
    } state_e;

endpackage

// File: rtl/iob_e_cycle_if.sv
// IO bus termination signals between the master sequencer side and the termination engine.
interface iob_e_cycle_if;
    logic       E_IOB;
    logic       nDTACK_IOB;
    logic       nVPA_IOB;
    logic       nBERR_IOB;
    logic       Active;
    logic       nVMA_IOB;
    logic       Done;
    logic [1:0] Term;
    logic [3:0] EPhase;

    modport master (
        output E_IOB, nDTACK_IOB, nVPA_IOB, nBERR_IOB, Active,
        input  nVMA_IOB, Done, Term, EPhase
    );

    modport slave (
        input  E_IOB, nDTACK_IOB, nVPA_IOB, nBERR_IOB, Active,
        output nVMA_IOB, Done, Term, EPhase
    );
endinterface

// File: rtl/iob_e_cycle_sync.sv
// N-stage flop synchroniser for active-low bus strobes; idles deasserted (1) out of reset.
module iob_e_cycle_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '1;
        end else begin
            r_q[0] <= i_d;
            for (int i = 1; i < int'(STAGES); i++) begin
                r_q[i] <= r_q[i-1];
            end
        end
    end

    assign o_q = r_q[STAGES-1];
endmodule

// File: rtl/iob_e_cycle.sv
// Resolves each IO bus cycle as DTACK, E-aligned VPA/VMA, bus error or local timeout,
// and tracks the E phase used to place nVMA.
module iob_e_cycle
    import iob_e_cycle_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned E_PERIOD     = E_PERIOD_DEF,
    parameter int unsigned VMA_PHASE    = VMA_PHASE_DEF,
    parameter int unsigned TIMEOUT_CLKS = 255
) (
    input  logic         CLK_IOB,
    input  logic         RES,
    iob_e_cycle_if.slave bus
);
    localparam logic [3:0] LP_PHASE_MAX = 4'(E_PERIOD - 1);
    localparam logic [3:0] LP_VMA_PHASE = 4'(VMA_PHASE);
    localparam logic [7:0] LP_TMO_LAST  = 8'(TIMEOUT_CLKS - 1);

    logic       w_ndtack_s;
    logic       w_nvpa_s;
    logic       w_nberr_s;
    logic       w_efall;
    logic       w_vma_slot;
    logic [3:0] w_ephase_d;

    state_e     r_state;
    logic       r_e_q;
    logic       r_nvma;
    logic       r_done;
    logic [1:0] r_term;
    logic [3:0] r_ephase;
    logic [7:0] r_tmo_cnt;

    iob_e_cycle_sync #(.STAGES(SYNC_STAGES)) u_sync_dtack (
        .i_clk (CLK_IOB),
        .i_rst (RES),
        .i_d   (bus.nDTACK_IOB),
        .o_q   (w_ndtack_s)
    );

    iob_e_cycle_sync #(.STAGES(SYNC_STAGES)) u_sync_vpa (
        .i_clk (CLK_IOB),
        .i_rst (RES),
        .i_d   (bus.nVPA_IOB),
        .o_q   (w_nvpa_s)
    );

    iob_e_cycle_sync #(.STAGES(SYNC_STAGES)) u_sync_berr (
        .i_clk (CLK_IOB),
        .i_rst (RES),
        .i_d   (bus.nBERR_IOB),
        .o_q   (w_nberr_s)
    );

    assign w_efall = r_e_q & ~bus.E_IOB;

    always_comb begin
        w_ephase_d = r_ephase;
        if (w_efall) begin
            w_ephase_d = '0;
        end else if (r_ephase != LP_PHASE_MAX) begin
            w_ephase_d = r_ephase + 4'd1;
        end
    end

    // Enter VMA on the edge that loads EPhase==VMA_PHASE so nVMA and the phase change together.
    assign w_vma_slot = (w_ephase_d == LP_VMA_PHASE) && !bus.E_IOB;

    always_ff @(posedge CLK_IOB) begin
        if (RES) begin
            r_state   <= StIdle;
            r_e_q     <= 1'b0;
            r_ephase  <= '0;
            r_nvma    <= 1'b1;
            r_done    <= 1'b0;
            r_term    <= TERM_DTACK;
            r_tmo_cnt <= '0;
        end else begin
            r_e_q    <= bus.E_IOB;
            r_ephase <= w_ephase_d;
            unique case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    r_nvma <= 1'b1;
                    if (bus.Active) begin
                        r_state   <= StWait;
                        r_tmo_cnt <= '0;
                    end
                end
                StWait: begin
                    if (!bus.Active) begin
                        r_state <= StIdle;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                        if (!w_nberr_s) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_term  <= TERM_BERR;
                        end else if (!w_ndtack_s) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_term  <= TERM_DTACK;
                        end else if (!w_nvpa_s) begin
                            r_state <= StVpaw;
                        end else if (r_tmo_cnt == LP_TMO_LAST) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_term  <= TERM_TMO;
                        end
                    end
                end
                StVpaw: begin
                    if (!bus.Active) begin
                        r_state <= StIdle;
                    end else if (!w_nberr_s) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                        r_term  <= TERM_BERR;
                    end else if (w_vma_slot) begin
                        r_state <= StVma;
                        r_nvma  <= 1'b0;
                    end
                end
                StVma: begin
                    // Entry needs E low, so the first EFall seen here always follows an E-high span.
                    if (!bus.Active) begin
                        r_state <= StIdle;
                        r_nvma  <= 1'b1;
                    end else if (w_efall) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                        r_term  <= TERM_VPA;
                        r_nvma  <= 1'b1;
                    end
                end
                StDone: begin
                    if (!bus.Active) begin
                        r_state <= StIdle;
                        r_done  <= 1'b0;
                        r_nvma  <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.nVMA_IOB = r_nvma;
    assign bus.Done     = r_done;
    assign bus.Term     = r_term;
    assign bus.EPhase   = r_ephase;
endmodule

// File: tb/tb_iob_e_cycle.sv
// Bench for iob_e_cycle: fixed vectors, hand-built abort/reset/stall sequences and random
// transactions predicted from the E timeline.
module tb_iob_e_cycle;
    localparam int S   = 2;
    localparam int EP  = 10;
    localparam int VP  = 2;
    localparam int TMO = 255;

    typedef struct {
        logic [2:0] mask;  // [0] DTACK, [1] VPA, [2] BERR
        int         phase;
        int         d;
        int         hold;
        int         lat;
        int         term;
        int         vlat;
        int         vcnt;
    } vec_t;

    typedef struct {
        int lat;
        int term;
        int vlat;
        int vcnt;
        int ph;
        int held;
        int clr;
        int nvclr;
    } obs_t;

    logic CLK_IOB = 1'b0;
    logic RES     = 1'b1;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    logic e_hold     = 1'b0;
    logic e_hold_val = 1'b0;

    iob_e_cycle_if bus ();

    iob_e_cycle #(
        .SYNC_STAGES  (S),
        .E_PERIOD     (EP),
        .VMA_PHASE    (VP),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .CLK_IOB (CLK_IOB),
        .RES     (RES),
        .bus     (bus)
    );

    always #5 CLK_IOB = ~CLK_IOB;

    always @(posedge CLK_IOB) cyc <= cyc + 1;

    // E as sampled at edge k: low for phases 0..5, high for 6..9.
    function automatic logic e_of(input int k);
        return (k % EP) >= 6;
    endfunction

    always @(posedge CLK_IOB) begin
        #1;
        bus.E_IOB = e_hold ? e_hold_val : e_of(cyc + 1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_IOB);
        #1;
    endtask

    task automatic start_at(input int p);
        do tick(); while ((cyc % EP) != p);
    endtask

    task automatic run_txn(input logic [2:0] mask, input int d, input int hold,
                           output int t0, output obs_t o);
        int done_e;
        int vlo;
        done_e = -1;
        vlo    = -1;
        o.vcnt = 0;
        o.term = -1;
        o.ph   = -1;
        t0 = cyc;
        bus.Active = 1'b1;
        while (done_e < 0 && cyc < t0 + TMO + 15) begin
            tick();
            if (!bus.nVMA_IOB) begin
                if (vlo < 0) vlo = cyc;
                o.vcnt++;
            end
            if (bus.Done) begin
                done_e = cyc;
                o.term = int'(bus.Term);
                o.ph   = int'(bus.EPhase);
            end
            if (cyc == t0 + d && mask != 3'b000) begin
                bus.nDTACK_IOB = ~mask[0];
                bus.nVPA_IOB   = ~mask[1];
                bus.nBERR_IOB  = ~mask[2];
            end
        end
        o.held = 1;
        repeat (hold) tick();
        if (hold > 0) o.held = int'(bus.Done);
        bus.Active     = 1'b0;
        bus.nDTACK_IOB = 1'b1;
        bus.nVPA_IOB   = 1'b1;
        bus.nBERR_IOB  = 1'b1;
        tick();
        o.clr   = int'(bus.Done);
        o.nvclr = int'(bus.nVMA_IOB);
        repeat (S + 3) tick();
        o.lat  = (done_e < 0) ? -1 : done_e - t0;
        o.vlat = (vlo < 0) ? 0 : vlo - t0;
    endtask

    // Outcome from the timeline: the response is acted on S+1 edges after it is driven;
    // VMA starts on the first later edge with phase VMA_PHASE and ends on the next E fall.
    task automatic predict(input logic [2:0] mask, input int t0, input int d, output vec_t e);
        int a;
        int v;
        int f;
        a = t0 + d + S + 1;
        e.vlat = 0;
        e.vcnt = 0;
        if (mask == 3'b000 || a > t0 + 1 + TMO) begin
            e.lat  = TMO + 1;
            e.term = 3;
        end else if (mask[2]) begin
            e.lat  = a - t0;
            e.term = 2;
        end else if (mask[0]) begin
            e.lat  = a - t0;
            e.term = 0;
        end else begin
            v = a + 1;
            while ((v % EP) != VP) v++;
            f = v + 1;
            while ((f % EP) != 0) f++;
            e.lat  = f - t0;
            e.term = 1;
            e.vlat = v - t0;
            e.vcnt = f - v;
        end
    endtask

    task automatic compare(input string tag, input int t0, input vec_t e, input int hold,
                           input obs_t o);
        chk({tag, " latency"}, o.lat, e.lat);
        chk({tag, " term"}, o.term, e.term);
        chk({tag, " vma_start"}, o.vlat, e.vlat);
        chk({tag, " vma_len"}, o.vcnt, e.vcnt);
        chk({tag, " ephase"}, o.ph, (t0 + e.lat) % EP);
        if (hold > 0) chk({tag, " done_held"}, o.held, 1);
        chk({tag, " done_clr"}, o.clr, 0);
        chk({tag, " nvma_clr"}, o.nvclr, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[11];
        vec_t e;
        obs_t o;
        int   t0;
        int   found;

        vecs[0]  = '{3'b001, 0, 4, 0, 7, 0, 0, 0};
        vecs[1]  = '{3'b100, 3, 2, 2, 5, 2, 0, 0};
        vecs[2]  = '{3'b111, 0, 1, 1, 4, 2, 0, 0};
        vecs[3]  = '{3'b011, 5, 3, 0, 6, 0, 0, 0};
        vecs[4]  = '{3'b010, 6, 1, 0, 14, 1, 6, 8};
        vecs[5]  = '{3'b010, 0, 2, 0, 20, 1, 12, 8};
        vecs[6]  = '{3'b010, 0, 9, 1, 30, 1, 22, 8};
        vecs[7]  = '{3'b010, 0, 8, 0, 20, 1, 12, 8};
        vecs[8]  = '{3'b110, 7, 10, 0, 13, 2, 0, 0};
        vecs[9]  = '{3'b001, 9, 1, 3, 4, 0, 0, 0};
        vecs[10] = '{3'b000, 4, 1, 2, 256, 3, 0, 0};

        bus.Active     = 1'b0;
        bus.nDTACK_IOB = 1'b1;
        bus.nVPA_IOB   = 1'b1;
        bus.nBERR_IOB  = 1'b1;

        repeat (3) tick();
        chk("reset done", int'(bus.Done), 0);
        chk("reset nvma", int'(bus.nVMA_IOB), 1);
        chk("reset term", int'(bus.Term), 0);
        chk("reset ephase", int'(bus.EPhase), 0);
        RES = 1'b0;
        repeat (25) tick();
        chk("ephase aligned", int'(bus.EPhase), cyc % EP);

        for (int i = 0; i < 11; i++) begin
            start_at(vecs[i].phase);
            run_txn(vecs[i].mask, vecs[i].d, vecs[i].hold, t0, o);
            compare($sformatf("vec%0d", i), t0, vecs[i], vecs[i].hold, o);
        end

        // Abort while nVMA is asserted.
        start_at(6);
        bus.Active = 1'b1;
        tick();
        bus.nVPA_IOB = 1'b0;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            tick();
            if (!bus.nVMA_IOB) found = 1;
        end
        chk("abort vma reached", found, 1);
        bus.Active = 1'b0;
        tick();
        chk("abort nvma", int'(bus.nVMA_IOB), 1);
        chk("abort done", int'(bus.Done), 0);
        repeat (3) tick();
        chk("abort done later", int'(bus.Done), 0);
        bus.nVPA_IOB = 1'b1;
        repeat (S + 3) tick();

        // Abort in WAIT before any response.
        bus.Active = 1'b1;
        repeat (5) tick();
        bus.Active = 1'b0;
        repeat (4) tick();
        chk("wait abort done", int'(bus.Done), 0);

        // Reset in the middle of a VMA cycle.
        start_at(6);
        bus.Active = 1'b1;
        tick();
        bus.nVPA_IOB = 1'b0;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            tick();
            if (!bus.nVMA_IOB) found = 1;
        end
        chk("rst vma reached", found, 1);
        RES          = 1'b1;
        bus.Active   = 1'b0;
        bus.nVPA_IOB = 1'b1;
        tick();
        RES = 1'b0;
        chk("rst nvma", int'(bus.nVMA_IOB), 1);
        chk("rst done", int'(bus.Done), 0);
        chk("rst ephase", int'(bus.EPhase), 0);
        chk("rst term", int'(bus.Term), 0);
        repeat (25) tick();

        // E stalled high: phase saturates, then realigns once E runs again.
        e_hold_val = 1'b1;
        e_hold     = 1'b1;
        repeat (15) tick();
        chk("ephase saturate", int'(bus.EPhase), EP - 1);
        e_hold = 1'b0;
        repeat (25) tick();
        chk("ephase realign", int'(bus.EPhase), cyc % EP);

        for (int i = 0; i < 30; i++) begin
            logic [2:0] mask;
            int         d;
            int         hold;
            mask = 3'($urandom_range(0, 7));
            if (mask == 3'b000 && ($urandom % 4) != 0) mask = 3'b010;
            d    = int'($urandom_range(1, 25));
            hold = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 9)) tick();
            run_txn(mask, d, hold, t0, o);
            predict(mask, t0, d, e);
            compare($sformatf("rnd%0d", i), t0, e, hold, o);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
